// File: rtl/io_hub_pkg.sv
// Shared constants and helpers for the processor I/O strobe hub.
// Strobe helpers work on a 32-bit view; callers size-cast in and out.
package io_hub_pkg;

    localparam int NUBITS_DEF = 31;
    localparam int NUIOIN_DEF = 4;
    localparam int NUIOOU_DEF = 4;
    localparam int FDEPTH_DEF = 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Isolates the lowest set bit, so only one channel is ever served per strobe
    function automatic logic [31:0] lowest_set(input logic [31:0] v);
        return v & (~v + 32'd1);
    endfunction

    function automatic logic multi_set(input logic [31:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Single-clock circular FIFO with registered count; head reads as 0 when empty.
// Push when full and pop when empty are ignored internally.
module io_fifo
    import io_hub_pkg::*;
#(
    parameter int WIDTH = 31,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [ptr_width(DEPTH):0]  count
);

    localparam int PW = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage is not reset: an empty FIFO never exposes stale entries
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_port_hub.sv
// Peripheral responder for the processor's one-hot I/O strobes: input FIFOs
// feed io_in on req_in, output FIFOs capture io_out on out_en and drain to sinks.
module io_port_hub
    import io_hub_pkg::*;
#(
    parameter int NUBITS = NUBITS_DEF,
    parameter int NUIOIN = NUIOIN_DEF,
    parameter int NUIOOU = NUIOOU_DEF,
    parameter int FDEPTH = FDEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUIOIN-1:0]         req_in,
    output logic [NUBITS-1:0]         io_in,
    input  logic [NUIOOU-1:0]         out_en,
    input  logic [NUBITS-1:0]         io_out,
    input  logic [NUIOIN*NUBITS-1:0]  src_data,
    input  logic [NUIOIN-1:0]         src_valid,
    output logic [NUIOIN-1:0]         src_ready,
    output logic [NUIOOU*NUBITS-1:0]  snk_data,
    output logic [NUIOOU-1:0]         snk_valid,
    input  logic [NUIOOU-1:0]         snk_ready,
    output logic [NUIOIN-1:0]         underflow,
    output logic [NUIOOU-1:0]         overflow,
    output logic                      strobe_err,
    input  logic                      clr_flags
);

    localparam int CW = ptr_width(FDEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FDEPTH);

    logic [NUIOIN-1:0]             req_sel;
    logic [NUIOIN-1:0]             in_push;
    logic [NUIOIN-1:0]             in_pop;
    logic [NUIOIN-1:0]             in_full;
    logic [NUIOIN-1:0]             in_empty;
    logic [NUIOIN-1:0]             under_set;
    logic [NUIOIN-1:0][NUBITS-1:0] in_head;
    logic [NUIOIN-1:0][CW-1:0]     in_count;
    logic [NUIOIN-1:0][NUBITS-1:0] hold;
    logic [NUBITS-1:0]             io_last;

    logic [NUIOOU-1:0]             out_sel;
    logic [NUIOOU-1:0]             out_push;
    logic [NUIOOU-1:0]             out_pop;
    logic [NUIOOU-1:0]             out_full;
    logic [NUIOOU-1:0]             out_empty;
    logic [NUIOOU-1:0]             over_set;
    logic [NUIOOU-1:0][CW-1:0]     out_count;
    logic                          strobe_set;

    assign req_sel    = NUIOIN'(lowest_set(32'(req_in)));
    assign out_sel    = NUIOOU'(lowest_set(32'(out_en)));
    assign strobe_set = multi_set(32'(req_in)) | multi_set(32'(out_en));

    for (genvar k = 0; k < NUIOIN; k++) begin : g_in
        assign src_ready[k] = (in_count[k] != FULL_CNT);
        assign in_push[k]   = src_valid[k] & ~in_full[k];
        assign in_pop[k]    = req_sel[k] & ~in_empty[k];
        assign under_set[k] = req_sel[k] & in_empty[k];

        io_fifo #(.WIDTH(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_push[k]),
            .pop   (in_pop[k]),
            .wdata (src_data[k*NUBITS +: NUBITS]),
            .head  (in_head[k]),
            .full  (in_full[k]),
            .empty (in_empty[k]),
            .count (in_count[k])
        );
    end

    for (genvar k = 0; k < NUIOOU; k++) begin : g_out
        assign snk_valid[k] = (out_count[k] != '0);
        assign out_push[k]  = out_sel[k] & ~out_full[k];
        assign out_pop[k]   = snk_ready[k] & ~out_empty[k];
        assign over_set[k]  = out_sel[k] & out_full[k];

        io_fifo #(.WIDTH(NUBITS), .DEPTH(FDEPTH)) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (out_push[k]),
            .pop   (out_pop[k]),
            .wdata (io_out),
            .head  (snk_data[k*NUBITS +: NUBITS]),
            .full  (out_full[k]),
            .empty (out_empty[k]),
            .count (out_count[k])
        );
    end

    // An empty channel replays its last popped value; no strobe replays the last driven value
    always_comb begin
        io_in = io_last;
        for (int k = 0; k < NUIOIN; k++) begin
            if (req_sel[k])
                io_in = in_empty[k] ? hold[k] : in_head[k];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold    <= '0;
            io_last <= '0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (in_pop[k])
                    hold[k] <= in_head[k];
            end
            if (|req_in)
                io_last <= io_in;
        end
    end

    // Sticky flags: a new event outranks a clear in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow  <= '0;
            overflow   <= '0;
            strobe_err <= 1'b0;
        end else begin
            underflow  <= (underflow & ~{NUIOIN{clr_flags}}) | under_set;
            overflow   <= (overflow & ~{NUIOOU{clr_flags}}) | over_set;
            strobe_err <= (strobe_err & ~clr_flags) | strobe_set;
        end
    end

endmodule

// File: tb/tb_io_port_hub.sv
// Directed self-checking bench for io_port_hub with hand-computed expectations.
module tb_io_port_hub;

    localparam int NB = 31;
    localparam logic [30:0] M7 = 31'h7FFF_FFF9;
    localparam logic [30:0] M2 = 31'h7FFF_FFFE;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [3:0]     req_in = '0;
    logic [NB-1:0]  io_in;
    logic [3:0]     out_en = '0;
    logic [NB-1:0]  io_out = '0;
    logic [4*NB-1:0] src_data = '0;
    logic [3:0]     src_valid = '0;
    logic [3:0]     src_ready;
    logic [4*NB-1:0] snk_data;
    logic [3:0]     snk_valid;
    logic [3:0]     snk_ready = '0;
    logic [3:0]     underflow;
    logic [3:0]     overflow;
    logic           strobe_err;
    logic           clr_flags = 1'b0;

    int checks = 0;
    int failures = 0;

    io_port_hub dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .io_in      (io_in),
        .out_en     (out_en),
        .io_out     (io_out),
        .src_data   (src_data),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .snk_data   (snk_data),
        .snk_valid  (snk_valid),
        .snk_ready  (snk_ready),
        .underflow  (underflow),
        .overflow   (overflow),
        .strobe_err (strobe_err),
        .clr_flags  (clr_flags)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] req, input logic [3:0] oen,
                                 input logic [NB-1:0] oval, input logic [3:0] sv,
                                 input logic [3:0] sr, input logic clr);
        req_in    = req;
        out_en    = oen;
        io_out    = oval;
        src_valid = sv;
        snk_ready = sr;
        clr_flags = clr;
        #1;
    endtask

    task automatic setSrc(input int ch, input logic [NB-1:0] val);
        src_data[ch*NB +: NB] = val;
    endtask

    initial begin
        tick();
        tick();
        checkOutput("rst_src_ready", 128'(src_ready), 128'(4'hF));
        checkOutput("rst_snk_valid", 128'(snk_valid), 128'(4'h0));
        checkOutput("rst_snk_data", 128'(snk_data), 128'(0));
        checkOutput("rst_io_in", 128'(io_in), 128'(0));
        checkOutput("rst_flags", 128'({underflow, overflow, strobe_err}), 128'(0));
        rst = 1'b0;

        // Channel 2: push 5, -7, 100 then read them back
        setSrc(2, 31'd5);   applyStimulus(4'b0000, 4'b0, '0, 4'b0100, 4'b0, 1'b0); tick();
        setSrc(2, M7);      applyStimulus(4'b0000, 4'b0, '0, 4'b0100, 4'b0, 1'b0); tick();
        setSrc(2, 31'd100); applyStimulus(4'b0000, 4'b0, '0, 4'b0100, 4'b0, 1'b0); tick();
        applyStimulus(4'b0100, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t1_read0", 128'(io_in), 128'(31'd5));
        tick(); #1;
        checkOutput("t1_read1", 128'(io_in), 128'(M7));
        tick(); #1;
        checkOutput("t1_read2", 128'(io_in), 128'(31'd100));
        tick();
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t1_ready", 128'(src_ready), 128'(4'hF));
        checkOutput("t1_idle_hold", 128'(io_in), 128'(31'd100));
        checkOutput("t1_no_underflow", 128'(underflow), 128'(4'h0));

        // Channel 0: fill, push held off, read with concurrent push attempt
        for (int i = 0; i < 4; i++) begin
            setSrc(0, 31'(10 + i));
            applyStimulus(4'b0000, 4'b0, '0, 4'b0001, 4'b0, 1'b0);
            tick();
        end
        checkOutput("t2_full", 128'(src_ready), 128'(4'b1110));
        setSrc(0, 31'd14);
        applyStimulus(4'b0000, 4'b0, '0, 4'b0001, 4'b0, 1'b0);
        tick();
        applyStimulus(4'b0001, 4'b0, '0, 4'b0001, 4'b0, 1'b0);
        checkOutput("t2_head", 128'(io_in), 128'(31'd10));
        checkOutput("t2_still_full", 128'(src_ready), 128'(4'b1110));
        tick();
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t2_ready_back", 128'(src_ready), 128'(4'hF));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0001, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
            checkOutput("t2_drain", 128'(io_in), 128'(31'(11 + i)));
            tick();
        end
        applyStimulus(4'b0001, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t2_empty_hold", 128'(io_in), 128'(31'd13));
        tick();
        checkOutput("t2_underflow", 128'(underflow), 128'(4'b0001));
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b1);
        tick();
        checkOutput("t2_clear", 128'(underflow), 128'(4'h0));

        // Channel 1: empty read, flag clear, set wins over clear
        setSrc(1, 31'd42);
        applyStimulus(4'b0000, 4'b0, '0, 4'b0010, 4'b0, 1'b0);
        tick();
        applyStimulus(4'b0010, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t3_read", 128'(io_in), 128'(31'd42));
        tick(); #1;
        checkOutput("t3_empty_hold", 128'(io_in), 128'(31'd42));
        tick();
        checkOutput("t3_underflow", 128'(underflow), 128'(4'b0010));
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b1);
        tick();
        checkOutput("t3_cleared", 128'(underflow), 128'(4'h0));
        applyStimulus(4'b0010, 4'b0, '0, 4'b0000, 4'b0, 1'b1);
        tick();
        checkOutput("t3_set_wins", 128'(underflow), 128'(4'b0010));
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b0);

        // Output channel 3: latency, overflow, full write with pop, drain order
        applyStimulus(4'b0000, 4'b1000, 31'h3FFF_FFFF, 4'b0, 4'b0000, 1'b0);
        checkOutput("t4_pre_valid", 128'(snk_valid), 128'(4'h0));
        tick();
        checkOutput("t4_valid", 128'(snk_valid), 128'(4'b1000));
        checkOutput("t4_data", 128'(snk_data[3*NB +: NB]), 128'(31'h3FFF_FFFF));
        applyStimulus(4'b0000, 4'b1000, 31'd1, 4'b0, 4'b0000, 1'b0); tick();
        applyStimulus(4'b0000, 4'b1000, M2, 4'b0, 4'b0000, 1'b0); tick();
        applyStimulus(4'b0000, 4'b1000, 31'h123_4567, 4'b0, 4'b0000, 1'b0); tick();
        checkOutput("t4_no_overflow", 128'(overflow), 128'(4'h0));
        applyStimulus(4'b0000, 4'b1000, 31'h55, 4'b0, 4'b0000, 1'b0); tick();
        checkOutput("t4_overflow", 128'(overflow), 128'(4'b1000));
        applyStimulus(4'b0000, 4'b1000, 31'h66, 4'b0, 4'b1000, 1'b0);
        checkOutput("t4_head0", 128'(snk_data[3*NB +: NB]), 128'(31'h3FFF_FFFF));
        tick();
        applyStimulus(4'b0000, 4'b0000, '0, 4'b0, 4'b1000, 1'b0);
        checkOutput("t4_head1", 128'(snk_data[3*NB +: NB]), 128'(31'd1));
        tick();
        checkOutput("t4_head2", 128'(snk_data[3*NB +: NB]), 128'(M2));
        tick();
        checkOutput("t4_head3", 128'(snk_data[3*NB +: NB]), 128'(31'h123_4567));
        tick();
        checkOutput("t4_drained", 128'(snk_valid), 128'(4'h0));
        applyStimulus(4'b0000, 4'b0000, '0, 4'b0, 4'b0000, 1'b1);
        tick();
        applyStimulus(4'b0000, 4'b0000, '0, 4'b0, 4'b0000, 1'b0);
        checkOutput("t4_cleared", 128'({overflow, strobe_err}), 128'(0));

        // Multi-bit strobes: lowest bit served, strobe_err raised
        setSrc(1, 31'd7);
        setSrc(2, 31'd8);
        applyStimulus(4'b0000, 4'b0, '0, 4'b0110, 4'b0, 1'b0);
        tick();
        applyStimulus(4'b0110, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t5_lowest", 128'(io_in), 128'(31'd7));
        tick();
        checkOutput("t5_strobe_err", 128'(strobe_err), 128'(1));
        applyStimulus(4'b0100, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t5_ch2_untouched", 128'(io_in), 128'(31'd8));
        tick();
        applyStimulus(4'b0000, 4'b0011, 31'd9, 4'b0000, 4'b0, 1'b0);
        tick();
        applyStimulus(4'b0000, 4'b0000, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t5_out_lowest", 128'(snk_valid), 128'(4'b0001));
        checkOutput("t5_out_data", 128'(snk_data[0 +: NB]), 128'(31'd9));

        // Asynchronous reset with data buffered on both sides
        setSrc(3, 31'd3);
        applyStimulus(4'b0000, 4'b0, '0, 4'b1000, 4'b0, 1'b0);
        tick();
        applyStimulus(4'b1000, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        checkOutput("t6_pre_rst", 128'(io_in), 128'(31'd3));
        rst = 1'b1;
        #1;
        checkOutput("t6_snk_valid", 128'(snk_valid), 128'(4'h0));
        checkOutput("t6_src_ready", 128'(src_ready), 128'(4'hF));
        checkOutput("t6_io_in", 128'(io_in), 128'(0));
        checkOutput("t6_snk_data", 128'(snk_data), 128'(0));
        checkOutput("t6_flags", 128'({underflow, overflow, strobe_err}), 128'(0));
        tick();
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0, '0, 4'b0000, 4'b0, 1'b0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
